// File: rtl/fetch_decode.sv
// Fetch/decode front end: PC, IR and data-address registers with instruction-field decode.
// Define FETCH_PERF_CNT_EN to build the saturating retired-fetch counter on instr_count.
module fetch_decode (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_pc,
    input  logic        clear_pc,
    input  logic        load_ir,
    input  logic        load_addr,
    input  logic        sel_addr,
    input  logic [1:0]  reg_sel,
    input  logic [15:0] ram_r_data,
    input  logic [15:0] datapath_out,
    output logic [7:0]  ram_addr,
    output logic [7:0]  pc,
    output logic [2:0]  opcode,
    output logic [1:0]  ALU_op,
    output logic [1:0]  shift_op,
    output logic [2:0]  r_addr,
    output logic [2:0]  w_addr,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8,
    output logic        halted,
    output logic [15:0] instr_count
);

    localparam int unsigned AW = 8;
    localparam int unsigned IW = 16;
    localparam logic [2:0]  OP_HALT = 3'b111;

    logic [IW-1:0] ir;
    logic [IW-1:0] ir_next;
    logic [AW-1:0] dar;
    logic [2:0]    reg_field;
    logic          pc_clear;
    logic          unused_dp_hi;

    assign ir_next      = load_ir ? ram_r_data : ir;
    assign pc_clear     = load_pc && clear_pc;
    assign unused_dp_hi = ^datapath_out[IW-1:AW];

    // Architectural registers; a clear request overrides the halt freeze.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= '0;
            ir     <= '0;
            dar    <= '0;
            halted <= 1'b0;
        end else begin
            if (pc_clear)
                pc <= '0;
            else if (load_pc && !halted)
                pc <= pc + AW'(1);

            if (load_ir)
                ir <= ram_r_data;

            if (load_addr)
                dar <= datapath_out[AW-1:0];

            if (pc_clear)
                halted <= 1'b0;
            else if (ir_next[15:13] == OP_HALT)
                halted <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [IW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load_pc && !clear_pc && !halted && (cnt != {IW{1'b1}}))
            cnt <= cnt + IW'(1);
    end

    assign instr_count = cnt;
`else
    assign instr_count = '0;
`endif

    always_comb begin
        reg_field = 3'b000;
        case (reg_sel)
            2'b10:   reg_field = ir[10:8];
            2'b01:   reg_field = ir[7:5];
            2'b00:   reg_field = ir[2:0];
            default: reg_field = 3'b000;
        endcase
    end

    assign ram_addr = sel_addr ? pc : dar;
    assign opcode   = ir[15:13];
    assign ALU_op   = ir[12:11];
    assign shift_op = ir[4:3];
    assign r_addr   = reg_field;
    assign w_addr   = reg_field;
    assign sximm5   = {{(IW-5){ir[4]}}, ir[4:0]};
    assign sximm8   = {{(IW-8){ir[7]}}, ir[7:0]};

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode; expected values are hand-computed constants.
module tb_fetch_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_pc, clear_pc, load_ir, load_addr, sel_addr;
    logic [1:0]  reg_sel;
    logic [15:0] ram_r_data, datapath_out;
    logic [7:0]  ram_addr, pc;
    logic [2:0]  opcode, r_addr, w_addr;
    logic [1:0]  ALU_op, shift_op;
    logic [15:0] sximm5, sximm8, instr_count;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_decode dut (
        .clk(clk), .rst(rst),
        .load_pc(load_pc), .clear_pc(clear_pc), .load_ir(load_ir),
        .load_addr(load_addr), .sel_addr(sel_addr), .reg_sel(reg_sel),
        .ram_r_data(ram_r_data), .datapath_out(datapath_out),
        .ram_addr(ram_addr), .pc(pc), .opcode(opcode), .ALU_op(ALU_op),
        .shift_op(shift_op), .r_addr(r_addr), .w_addr(w_addr),
        .sximm5(sximm5), .sximm8(sximm8), .halted(halted),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Counter expectation: the hand count when the counter is built, else constant 0.
    task automatic check_cnt(input string tag, input logic [15:0] exp);
`ifdef FETCH_PERF_CNT_EN
        check(tag, 32'(instr_count), 32'(exp));
`else
        check(tag, 32'(instr_count), 32'h0);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        load_pc = 1'b0; clear_pc = 1'b0; load_ir = 1'b0; load_addr = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; idle(); sel_addr = 1'b1; reg_sel = 2'b00;
        ram_r_data = 16'h0000; datapath_out = 16'h0000;

        #3;
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_ram_addr", 32'(ram_addr), 32'h0);
        check("rst_opcode", 32'(opcode), 32'h0);
        check("rst_alu_op", 32'(ALU_op), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check_cnt("rst_cnt", 16'h0);
        tick(); tick();
        rst = 1'b0;

        // Reset followed by a clear.
        load_pc = 1'b1; clear_pc = 1'b1;
        tick();
        check("clr_pc", 32'(pc), 32'h0);
        check("clr_ram_addr", 32'(ram_addr), 32'h0);
        check("clr_halted", 32'(halted), 32'h0);
        check_cnt("clr_cnt", 16'd0);

        // Count up to 0xFF, then wrap.
        clear_pc = 1'b0;
        for (int i = 0; i < 255; i++) tick();
        check("pc_ff", 32'(pc), 32'hFF);
        check_cnt("cnt_255", 16'd255);
        tick();
        check("pc_wrap", 32'(pc), 32'h00);
        check_cnt("cnt_wrap", 16'd256);

        // IR and PC load on the same edge.
        load_ir = 1'b1; ram_r_data = 16'hA1F8;
        tick();
        idle();
        check("dual_pc", 32'(pc), 32'h01);
        check_cnt("dual_cnt", 16'd257);
        check("a1f8_opcode", 32'(opcode), 32'h5);
        check("a1f8_alu", 32'(ALU_op), 32'h0);
        check("a1f8_shift", 32'(shift_op), 32'h3);
        reg_sel = 2'b10; #1;
        check("a1f8_rn", 32'(r_addr), 32'd1);
        reg_sel = 2'b01; #1;
        check("a1f8_rd", 32'(w_addr), 32'd7);
        reg_sel = 2'b00; #1;
        check("a1f8_rm", 32'(r_addr), 32'd0);
        check("a1f8_sx8", 32'(sximm8), 32'hFFF8);
        check("a1f8_sx5", 32'(sximm5), 32'hFFF8);

        // Positive immediates and distinct register fields.
        load_ir = 1'b1; ram_r_data = 16'h4A65;
        tick();
        idle();
        check("4a65_opcode", 32'(opcode), 32'h2);
        check("4a65_alu", 32'(ALU_op), 32'h1);
        check("4a65_shift", 32'(shift_op), 32'h0);
        reg_sel = 2'b10; #1;
        check("4a65_rn", 32'(w_addr), 32'd2);
        reg_sel = 2'b01; #1;
        check("4a65_rd", 32'(r_addr), 32'd3);
        reg_sel = 2'b00; #1;
        check("4a65_rm", 32'(w_addr), 32'd5);
        reg_sel = 2'b11; #1;
        check("4a65_zero", 32'(r_addr), 32'd0);
        check("4a65_sx8", 32'(sximm8), 32'h0065);
        check("4a65_sx5", 32'(sximm5), 32'h0005);

        // IR holds without load_ir.
        ram_r_data = 16'hFFFF;
        tick();
        check("ir_hold", 32'(opcode), 32'h2);

        // Data-address register takes the low byte only.
        load_addr = 1'b1; datapath_out = 16'h1234;
        tick();
        idle(); datapath_out = 16'hABCD;
        tick();
        sel_addr = 1'b0; #1;
        check("dar_addr", 32'(ram_addr), 32'h34);
        sel_addr = 1'b1; #1;
        check("pc_addr", 32'(ram_addr), 32'h01);

        // HALT freezes the PC until a clear.
        load_ir = 1'b1; ram_r_data = 16'hE000;
        tick();
        idle();
        check("halt_set", 32'(halted), 32'h1);
        check("halt_opcode", 32'(opcode), 32'h7);
        load_pc = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("halt_pc_frozen", 32'(pc), 32'h01);
        check_cnt("halt_cnt", 16'd257);
        clear_pc = 1'b1;
        tick();
        idle();
        check("halt_clr_pc", 32'(pc), 32'h00);
        check("halt_clr_prio", 32'(halted), 32'h0);
        load_ir = 1'b1; ram_r_data = 16'h0000;
        tick();
        idle();
        check("nohalt", 32'(halted), 32'h0);

        // clear_pc alone leaves the PC alone.
        load_pc = 1'b1;
        tick(); tick();
        load_pc = 1'b0; clear_pc = 1'b1;
        tick();
        clear_pc = 1'b0;
        check("clear_only", 32'(pc), 32'h02);
        check_cnt("clear_only_cnt", 16'd259);

        // Reach pc=5 with a HALT captured on the last edge.
        load_pc = 1'b1;
        tick(); tick();
        load_ir = 1'b1; ram_r_data = 16'hE000;
        tick();
        idle();
        check("pre_rst_pc", 32'(pc), 32'h05);
        check("pre_rst_halt", 32'(halted), 32'h1);
        check_cnt("pre_rst_cnt", 16'd262);

        // Asynchronous reset between edges.
        #2 rst = 1'b1;
        #1;
        check("arst_pc", 32'(pc), 32'h0);
        check("arst_halted", 32'(halted), 32'h0);
        check("arst_opcode", 32'(opcode), 32'h0);
        check_cnt("arst_cnt", 16'd0);
        load_pc = 1'b1;
        tick();
        check("rst_discard", 32'(pc), 32'h0);
        rst = 1'b0;
        tick();
        check("post_rst_pc", 32'(pc), 32'h01);
        check_cnt("post_rst_cnt", 16'd1);

`ifdef FETCH_PERF_CNT_EN
        for (int i = 0; i < 70000; i++) tick();
        check("sat_cnt", 32'(instr_count), 32'hFFFF);
        check("sat_pc", 32'(pc), 32'h71);
`endif
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_decode.md
FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: clk and rst; rst asserts asynchronously and releases synchronously to clk.
REQ-002 The block SHALL have no parameters; the PC and data-address width is fixed at 8 bits and the instruction width at 16 bits.
REQ-003 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- load_pc  in  1  PC update enable
- clear_pc  in  1  selects 0 as next PC
- load_ir  in  1  IR capture enable
- load_addr  in  1  data-address register capture enable
- sel_addr  in  1  1 = PC drives ram_addr; 0 = DAR drives ram_addr
- reg_sel  in  2  register-field select
- ram_r_data  in  16  RAM read data
- datapath_out  in  16  datapath result (address source)
- ram_addr  out  8  RAM address
- pc  out  8  program counter
- opcode  out  3  ir[15:13]
- ALU_op  out  2  ir[12:11]
- shift_op  out  2  ir[4:3]
- r_addr  out  3  register read index
- w_addr  out  3  register write index
- sximm5  out  16  ir[4:0] sign-extended
- sximm8  out  16  ir[7:0] sign-extended
- halted  out  1  a HALT instruction is held in the IR
- instr_count  out  16  retired-fetch counter

Function
REQ-004 PC register: on a clk edge with load_pc=1 and halted=0, the PC SHALL load 0 if clear_pc=1, otherwise pc+1 mod 256 (255 wraps to 0); otherwise it SHALL hold.
REQ-005 clear_pc=1 together with load_pc=1 SHALL load 0 even when halted=1; clear_pc without load_pc SHALL leave the PC unchanged.
REQ-006 IR: on a clk edge with load_ir=1, the IR SHALL capture ram_r_data; otherwise it SHALL hold. A new value is visible on the decode outputs in the cycle after the edge.
REQ-007 DAR: on a clk edge with load_addr=1, the DAR SHALL capture datapath_out[7:0]; datapath_out[15:8] SHALL be ignored.
REQ-008 ram_addr SHALL be combinational: pc when sel_addr=1, DAR when sel_addr=0.
REQ-009 r_addr and w_addr SHALL both be combinational from the IR and reg_sel:
- 2'b10 selects Rn = ir[10:8]
- 2'b01 selects Rd = ir[7:5]
- 2'b00 selects Rm = ir[2:0]
- 2'b11 selects 3'b000
REQ-010 sximm5 and sximm8 SHALL replicate ir[4] and ir[7] respectively into all upper bits.
REQ-011 halted SHALL be a register:
- set on the edge after which the IR holds opcode 3'b111
- cleared on any edge with load_pc=1 and clear_pc=1
- clear has priority over set in the same cycle
REQ-012 If load_ir and load_pc assert in the same cycle, both registers SHALL update independently on that edge.

Reset
REQ-013 While rst=1, pc, the IR, the DAR and halted SHALL all be 0. As a result, ram_addr=0, opcode=0, ALU_op=0 and instr_count=0.
REQ-014 rst asserted mid-operation SHALL discard any pending load in that cycle; the first post-reset edge SHALL behave per REQ-004 to REQ-011.

Configuration
REQ-015 The macro FETCH_PERF_CNT_EN SHALL control the instruction counter.
- Defined: instr_count SHALL increment by 1 on each edge with load_pc=1, clear_pc=0 and halted=0, saturate at 16'hFFFF, and reset to 0 only on rst.
- Undefined: instr_count SHALL be constant 0, and no counter flops SHALL be present.

Verification
REQ-016 Reset, then load_pc=1 with clear_pc=1 -> pc=0x00, ram_addr=0x00 (sel_addr=1), halted=0.
REQ-017 pc=0xFF, load_pc=1, clear_pc=0 -> pc=0x00 on the next edge; with FETCH_PERF_CNT_EN, instr_count increments by 1.
REQ-018 load_ir with ram_r_data=16'hA1F8 -> opcode=3'b101, ALU_op=2'b00, reg_sel=2'b10 gives r_addr=3'd1, reg_sel=2'b01 gives w_addr=3'd7, sximm8=16'hFFF8, sximm5=16'hFFF8.
REQ-019 load_addr with datapath_out=16'h1234, then sel_addr=0 -> ram_addr=0x34; sel_addr=1 -> ram_addr=pc.
REQ-020 load_ir with ram_r_data=16'hE000 -> halted=1 next cycle; subsequent load_pc pulses leave pc frozen; load_pc with clear_pc -> pc=0, halted=0.
REQ-021 rst asserted between clock edges with pc=0x05 -> pc and halted read 0 immediately, with no clock edge; with FETCH_PERF_CNT_EN, 70000 load_pc pulses -> instr_count=16'hFFFF.
